timer_host_master: RTL and testbench



---
 rtl/timer_host_pkg.sv | 36 +++
 rtl/timer_host_if.sv | 22 ++
 rtl/timer_tick_counter.sv | 25 ++
 rtl/timer_host_master.sv | 144 ++++++++++++++
 tb/tb_timer_host_master.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_host_pkg.sv
// Shared definitions for the interval-timer host master: slave register map,
// control-register bit positions and the sequencing FSM state type.
package timer_host_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic [15:0] CTRL_GO_WORD =
    (16'd1 << CTRL_ITO) | (16'd1 << CTRL_CONT) | (16'd1 << CTRL_START);
  localparam logic [15:0] CTRL_STOP_WORD = 16'd1 << CTRL_STOP;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RUN,
    ST_STOP,
    ST_CLR,
    ST_CLR_WAIT,
    ST_SNAP_WR,
    ST_SNAP_RL,
    ST_SNAP_RH,
    ST_SNAP_DONE
  } state_t;

endpackage

// File: rtl/timer_host_if.sv
// Avalon-MM link between the host master and the interval-timer slave,
// plus the timer's level interrupt.
interface timer_host_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        timer_irq;

  // Writes are single-cycle (no waitrequest); reads hold address and return
  // av_readdata one cycle later.
  modport master (
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_readdata, timer_irq
  );

  modport slave (
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_readdata, timer_irq
  );
endinterface

// File: rtl/timer_tick_counter.sv
// Modulo tick counter: counts serviced timeouts and flags the wrap to zero.
module timer_tick_counter #(
    parameter int TICK_W    = 17,
    parameter int TICK_WRAP = 86400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [TICK_W-1:0] tick_count,
    output logic              day_wrap
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_WRAP - 1);

    assign day_wrap = inc && (tick_count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count <= '0;
        end else if (inc) begin
            tick_count <= day_wrap ? '0 : tick_count + TICK_W'(1);
        end
    end

endmodule

// File: rtl/timer_host_master.sv
// Avalon-MM master that programs the interval timer, services its interrupt
// into a wrapping tick count, and performs 32-bit counter snapshots.
module timer_host_master
  import timer_host_pkg::*;
#(
    parameter logic [31:0] DEFAULT_PERIOD = 32'h02FAF07F,
    parameter int          TICK_W         = 17,
    parameter int          TICK_WRAP      = 86400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              snap_req,
    input  logic [31:0]       period_in,
    timer_host_if.master      bus,
    output logic              running,
    output logic              busy,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              day_wrap,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output state_t            state_dbg
);

    state_t      state, state_nxt;
    logic [31:0] period_q;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            period_q   <= '0;
            running    <= 1'b0;
            snap_value <= '0;
            snap_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            snap_valid <= (state == ST_SNAP_DONE);
            if (state == ST_IDLE && cfg_start)
                period_q <= (period_in == 32'd0) ? DEFAULT_PERIOD : period_in;
            if (state == ST_WR_CTRL)
                running <= 1'b1;
            else if (state == ST_STOP)
                running <= 1'b0;
            // Read data trails the read address by one cycle.
            if (state == ST_SNAP_RH)
                snap_value[15:0] <= bus.av_readdata;
            if (state == ST_SNAP_DONE)
                snap_value[31:16] <= bus.av_readdata;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.av_address    = '0;
        bus.av_chipselect = 1'b0;
        bus.av_write_n    = 1'b1;
        bus.av_writedata  = '0;
        tick              = 1'b0;
        busy              = 1'b1;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (cfg_start) state_nxt = ST_WR_PL;
            end
            ST_WR_PL: begin
                bus.av_address    = ADDR_PERIOD_L;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_writedata  = period_q[15:0];
                state_nxt         = ST_WR_PH;
            end
            ST_WR_PH: begin
                bus.av_address    = ADDR_PERIOD_H;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_writedata  = period_q[31:16];
                state_nxt         = ST_WR_CTRL;
            end
            ST_WR_CTRL: begin
                bus.av_address    = ADDR_CONTROL;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_writedata  = CTRL_GO_WORD;
                state_nxt         = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b0;
                if (cfg_stop)           state_nxt = ST_STOP;
                else if (bus.timer_irq) state_nxt = ST_CLR;
                else if (snap_req)      state_nxt = ST_SNAP_WR;
            end
            ST_STOP: begin
                bus.av_address    = ADDR_CONTROL;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                bus.av_writedata  = CTRL_STOP_WORD;
                state_nxt         = ST_IDLE;
            end
            ST_CLR: begin
                bus.av_address    = ADDR_STATUS;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                tick              = 1'b1;
                state_nxt         = ST_CLR_WAIT;
            end
            // The irq level is still stale here; let it drop before RUN samples it.
            ST_CLR_WAIT: state_nxt = ST_RUN;
            ST_SNAP_WR: begin
                bus.av_address    = ADDR_SNAP_L;
                bus.av_chipselect = 1'b1;
                bus.av_write_n    = 1'b0;
                state_nxt         = ST_SNAP_RL;
            end
            ST_SNAP_RL: begin
                bus.av_address    = ADDR_SNAP_L;
                bus.av_chipselect = 1'b1;
                state_nxt         = ST_SNAP_RH;
            end
            ST_SNAP_RH: begin
                bus.av_address    = ADDR_SNAP_H;
                bus.av_chipselect = 1'b1;
                state_nxt         = ST_SNAP_DONE;
            end
            ST_SNAP_DONE: state_nxt = ST_RUN;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    timer_tick_counter #(
        .TICK_W   (TICK_W),
        .TICK_WRAP(TICK_WRAP)
    ) u_tick_counter (
        .clk       (clk),
        .reset     (reset),
        .inc       (tick),
        .tick_count(tick_count),
        .day_wrap  (day_wrap)
    );

endmodule

// File: tb/tb_timer_host_master.sv
// Directed bench for timer_host_master with a small registered timer-slave model
// and an expected-write queue checked against every bus write.
module tb_timer_host_master;
    import timer_host_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic        snap_req = 1'b0;
    logic [31:0] period_in = '0;
    logic        irq = 1'b0;
    logic [15:0] rdata = '0;
    logic        running, busy, tick, day_wrap, snap_valid;
    logic [16:0] tick_count;
    logic [31:0] snap_value;
    state_t      state_dbg;

    timer_host_if bus ();
    assign bus.timer_irq   = irq;
    assign bus.av_readdata = rdata;

    always #5 clk = ~clk;

    timer_host_master #(.TICK_WRAP(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .snap_req  (snap_req),
        .period_in (period_in),
        .bus       (bus),
        .running   (running),
        .busy      (busy),
        .tick      (tick),
        .tick_count(tick_count),
        .day_wrap  (day_wrap),
        .snap_value(snap_value),
        .snap_valid(snap_valid),
        .state_dbg (state_dbg)
    );

    // Slave model: snapshot latched on write to SNAP_L, reads registered.
    logic [31:0] snap_src = 32'h00561234;
    logic [31:0] snap_reg = '0;
    always @(posedge clk) begin
        if (bus.av_chipselect && !bus.av_write_n && bus.av_address == ADDR_SNAP_L)
            snap_reg <= snap_src;
        if (bus.av_chipselect && bus.av_write_n) begin
            case (bus.av_address)
                ADDR_SNAP_L: rdata <= snap_reg[15:0];
                ADDR_SNAP_H: rdata <= snap_reg[31:16];
                default:     rdata <= 16'h0000;
            endcase
        end
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard: every write on the bus must match the head of exp_q.
    logic [18:0] exp_q[$];
    always @(negedge clk) begin
        if (bus.av_chipselect === 1'b1 && bus.av_write_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data %h expected none",
                         bus.av_address, bus.av_writedata);
            end else begin
                check("bus_write", {13'd0, bus.av_address, bus.av_writedata}, {13'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first RUN cycle.
    task automatic program_timer(input logic [31:0] p, input logic [15:0] pl, input logic [15:0] ph);
        period_in = p;
        cfg_start = 1'b1;
        exp_q.push_back({ADDR_PERIOD_L, pl});
        exp_q.push_back({ADDR_PERIOD_H, ph});
        exp_q.push_back({ADDR_CONTROL, 16'h0007});
        step();
        cfg_start = 1'b0;
        check("busy_in_wr_pl", busy, 1);
        check("running_before_start", running, 0);
        step();
        step();
        check("running_in_wr_ctrl", running, 0);
        step();
        check("running_after_4", running, 1);
        check("busy_in_run", busy, 0);
        check("state_run", state_dbg, ST_RUN);
    endtask

    task automatic stop_timer();
        cfg_stop = 1'b1;
        exp_q.push_back({ADDR_CONTROL, 16'h0008});
        step();
        cfg_stop = 1'b0;
        check("running_in_stop", running, 1);
        step();
        check("running_after_stop", running, 0);
        check("state_idle_after_stop", state_dbg, ST_IDLE);
    endtask

    typedef struct {
        logic [31:0] period;
        logic [15:0] pl;
        logic [15:0] ph;
    } prog_vec_t;

    prog_vec_t vecs[3];
    int exp_tc = 0;

    initial begin
        vecs[0] = '{period: 32'd99,         pl: 16'h0063, ph: 16'h0000};
        vecs[1] = '{period: 32'd0,          pl: 16'hF07F, ph: 16'h02FA};
        vecs[2] = '{period: 32'h12345678,   pl: 16'h5678, ph: 16'h1234};

        // Reset state
        repeat (3) step();
        check("rst_cs", bus.av_chipselect, 0);
        check("rst_write_n", bus.av_write_n, 1);
        check("rst_addr", bus.av_address, 0);
        check("rst_wdata", bus.av_writedata, 0);
        check("rst_running", running, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        check("rst_tick_count", tick_count, 0);
        check("rst_snap", {snap_valid, snap_value}, 0);
        reset = 1'b0;
        step();

        // Reset in the middle of WR_PH
        period_in = 32'd99;
        cfg_start = 1'b1;
        exp_q.push_back({ADDR_PERIOD_L, 16'h0063});
        exp_q.push_back({ADDR_PERIOD_H, 16'h0000});
        step();
        cfg_start = 1'b0;
        step();
        check("mid_state_wr_ph", state_dbg, ST_WR_PH);
        reset = 1'b1;
        step();
        check("mid_rst_cs", bus.av_chipselect, 0);
        check("mid_rst_write_n", bus.av_write_n, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_running", running, 0);
        check("mid_rst_tick_count", tick_count, 0);
        reset = 1'b0;
        step();

        // Stop/snapshot requests outside RUN are dropped
        cfg_stop = 1'b1;
        snap_req = 1'b1;
        step();
        cfg_stop = 1'b0;
        snap_req = 1'b0;
        check("idle_ignore_state", state_dbg, ST_IDLE);
        step();
        check("idle_ignore_busy", busy, 0);

        // Programming table, each followed by a stop
        for (int i = 0; i < 3; i++) begin
            program_timer(vecs[i].period, vecs[i].pl, vecs[i].ph);
            stop_timer();
        end

        program_timer(32'd99, 16'h0063, 16'h0000);
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("start_in_run_ignored", state_dbg, ST_RUN);

        // irq held 3 cycles -> exactly one tick
        irq = 1'b1;
        exp_q.push_back({ADDR_STATUS, 16'h0000});
        step();
        check("irq_tick", tick, 1);
        check("irq_tc_before", tick_count, 0);
        step();
        check("clr_wait_no_tick", tick, 0);
        check("irq_tc_after", tick_count, 1);
        step();
        irq = 1'b0;
        check("back_in_run", state_dbg, ST_RUN);
        step();
        check("no_second_tick", tick, 0);
        exp_tc = 1;

        // Snapshot
        snap_req = 1'b1;
        exp_q.push_back({ADDR_SNAP_L, 16'h0000});
        step();
        snap_req = 1'b0;
        check("snap_wr_busy", busy, 1);
        step();
        check("snap_rl_read", {bus.av_chipselect, bus.av_write_n, 1'b0, bus.av_address}, {1'b1, 1'b1, 1'b0, ADDR_SNAP_L});
        step();
        check("snap_rh_read", {bus.av_chipselect, bus.av_write_n, 1'b0, bus.av_address}, {1'b1, 1'b1, 1'b0, ADDR_SNAP_H});
        step();
        check("snap_valid_early", snap_valid, 0);
        step();
        check("snap_valid_5", snap_valid, 1);
        check("snap_value", snap_value, 32'h00561234);
        step();
        check("snap_valid_pulse", snap_valid, 0);

        // irq raised during a snapshot is serviced afterwards
        snap_src = 32'hABCD0042;
        snap_req = 1'b1;
        exp_q.push_back({ADDR_SNAP_L, 16'h0000});
        step();
        snap_req = 1'b0;
        step();
        irq = 1'b1;
        step();
        step();
        check("snap_irq_no_tick", tick, 0);
        step();
        check("snap2_valid", snap_valid, 1);
        check("snap2_value", snap_value, 32'hABCD0042);
        exp_q.push_back({ADDR_STATUS, 16'h0000});
        step();
        irq = 1'b0;
        check("deferred_tick", tick, 1);
        step();
        exp_tc = 2;
        check("deferred_tc", tick_count, exp_tc);
        step();

        // Four serviced irqs across the TICK_WRAP=4 boundary
        for (int k = 0; k < 4; k++) begin
            irq = 1'b1;
            exp_q.push_back({ADDR_STATUS, 16'h0000});
            step();
            irq = 1'b0;
            check("wrap_tick", tick, 1);
            check("wrap_tc_pre", tick_count, exp_tc);
            check("wrap_day_wrap", day_wrap, (exp_tc == 3) ? 1 : 0);
            step();
            exp_tc = (exp_tc + 1) % 4;
            check("wrap_tc_post", tick_count, exp_tc);
            check("wrap_no_day_wrap", day_wrap, 0);
            step();
        end

        // Simultaneous stop and irq: stop wins
        cfg_stop = 1'b1;
        irq = 1'b1;
        exp_q.push_back({ADDR_CONTROL, 16'h0008});
        step();
        cfg_stop = 1'b0;
        check("stop_wins_state", state_dbg, ST_STOP);
        check("stop_wins_no_tick", tick, 0);
        step();
        check("stop_wins_running", running, 0);
        check("stop_wins_tc", tick_count, exp_tc);
        step();
        check("idle_irq_ignored", state_dbg, ST_IDLE);
        irq = 1'b0;

        // Restart reprograms normally; counters retained
        program_timer(vecs[1].period, vecs[1].pl, vecs[1].ph);
        check("restart_tc_kept", tick_count, exp_tc);
        check("restart_snap_kept", snap_value, 32'hABCD0042);
        stop_timer();
        step();

        check("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
